// File: rtl/qeciphy_link_ctrl_if.sv
// qeciphy_link_ctrl_if: PHY-side bundle (STATUS/ECODE/PACCEPT from PHY; PHY_ARSTn/PSTATE/PREQ to PHY)
interface qeciphy_link_ctrl_if;
  logic [3:0] STATUS;
  logic [3:0] ECODE;
  logic PACCEPT;
  logic PHY_ARSTn;
  logic PSTATE;
  logic PREQ;
  modport master(input STATUS, ECODE, PACCEPT, output PHY_ARSTn, PSTATE, PREQ);
  modport slave(output STATUS, ECODE, PACCEPT, input PHY_ARSTn, PSTATE, PREQ);
endinterface

// File: rtl/qeciphy_link_ctrl.sv
// qeciphy_link_ctrl: PHY reset/link-up/power-handshake/retry FSM (ACLK, ARST, EN, PWR_REQ in; phy bundle; LINK_UP, FAULT, RETRY_CNT, LAST_ECODE, CTRL_STATE out)
module qeciphy_link_ctrl #(
  parameter int RST_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRY = 3
) (
  input  logic ACLK,
  input  logic ARST,
  input  logic EN,
  input  logic PWR_REQ,
  qeciphy_link_ctrl_if.master phy,
  output logic LINK_UP,
  output logic FAULT,
  output logic [3:0] RETRY_CNT,
  output logic [3:0] LAST_ECODE,
  output logic [2:0] CTRL_STATE
);
  typedef enum logic [2:0] {
    S_IDLE, S_PHY_RST, S_WAIT_LINK, S_RUN, S_PWR_DN, S_LOWPWR, S_PWR_UP, S_FAULT
  } state_t;
  localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES - 1);
  localparam logic [23:0] TMAX = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] RMAX = 4'(MAX_RETRY);
  state_t state;
  logic [7:0] rst_cnt;
  logic [23:0] timer;
  logic arst_n, pstate, preq;
  logic link_ok, tmo, fail;
  assign link_ok = phy.STATUS == 4'b0100 && phy.ECODE == 4'd0;
  assign tmo = timer == TMAX;
  assign fail = state == S_RUN ? !link_ok :
                state == S_WAIT_LINK ? !link_ok && tmo :
                (state == S_PWR_DN || state == S_PWR_UP) ? !phy.PACCEPT && tmo : 1'b0;
  assign phy.PHY_ARSTn = arst_n;
  assign phy.PSTATE = pstate;
  assign phy.PREQ = preq;
  assign CTRL_STATE = state;
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state <= S_IDLE;
      arst_n <= 1'b0;
      pstate <= 1'b1;
      preq <= 1'b0;
      LINK_UP <= 1'b0;
      FAULT <= 1'b0;
      RETRY_CNT <= 4'd0;
      LAST_ECODE <= 4'd0;
      rst_cnt <= 8'd0;
      timer <= 24'd0;
    end else begin
      timer <= tmo ? timer : timer + 24'd1;
      if (!EN) begin
        state <= S_IDLE;
        arst_n <= 1'b0;
        pstate <= 1'b1;
        preq <= 1'b0;
        LINK_UP <= 1'b0;
        FAULT <= 1'b0;
        RETRY_CNT <= state == S_FAULT ? 4'd0 : RETRY_CNT;
      end else if (fail) begin
        LAST_ECODE <= phy.ECODE;
        arst_n <= 1'b0;
        pstate <= 1'b1;
        preq <= 1'b0;
        LINK_UP <= 1'b0;
        if (RETRY_CNT == RMAX) begin
          state <= S_FAULT;
          FAULT <= 1'b1;
        end else begin
          state <= S_PHY_RST;
          RETRY_CNT <= RETRY_CNT + 4'd1;
          rst_cnt <= RST_LOAD;
        end
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_PHY_RST;
            rst_cnt <= RST_LOAD;
          end
          S_PHY_RST: begin
            rst_cnt <= rst_cnt - 8'd1;
            if (rst_cnt == 8'd0) begin
              state <= S_WAIT_LINK;
              arst_n <= 1'b1;
              timer <= 24'd0;
            end
          end
          S_WAIT_LINK: if (link_ok) begin
            state <= S_RUN;
            LINK_UP <= 1'b1;
            RETRY_CNT <= 4'd0;
          end
          S_RUN: if (!PWR_REQ) begin
            state <= S_PWR_DN;
            pstate <= 1'b0;
            preq <= 1'b1;
            LINK_UP <= 1'b0;
            timer <= 24'd0;
          end
          S_PWR_DN: if (phy.PACCEPT) begin
            state <= S_LOWPWR;
            preq <= 1'b0;
          end
          S_LOWPWR: if (PWR_REQ) begin
            state <= S_PWR_UP;
            pstate <= 1'b1;
            preq <= 1'b1;
            timer <= 24'd0;
          end
          S_PWR_UP: if (phy.PACCEPT) begin
            state <= S_WAIT_LINK;
            preq <= 1'b0;
            timer <= 24'd0;
          end
          default: state <= S_FAULT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_qeciphy_link_ctrl.sv
// tb_qeciphy_link_ctrl: scoreboard bench for the link controller
module tb_qeciphy_link_ctrl;
  logic ACLK, ARST, EN, PWR_REQ;
  logic LINK_UP, FAULT;
  logic [3:0] RETRY_CNT, LAST_ECODE;
  logic [2:0] CTRL_STATE;
  int vectors = 0;
  int miscompares = 0;
  logic [15:0] sb[$];
  logic [15:0] exp, got;
  qeciphy_link_ctrl_if phy ();
  qeciphy_link_ctrl #(.RST_CYCLES(16), .TIMEOUT_CYCLES(64), .MAX_RETRY(3)) dut (
    .ACLK(ACLK), .ARST(ARST), .EN(EN), .PWR_REQ(PWR_REQ), .phy(phy.master),
    .LINK_UP(LINK_UP), .FAULT(FAULT), .RETRY_CNT(RETRY_CNT),
    .LAST_ECODE(LAST_ECODE), .CTRL_STATE(CTRL_STATE)
  );
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  function automatic logic [15:0] obs();
    return {CTRL_STATE, phy.PHY_ARSTn, phy.PSTATE, phy.PREQ, LINK_UP, FAULT, RETRY_CNT, LAST_ECODE};
  endfunction
  function automatic logic [15:0] mk(input logic [2:0] s, input logic [4:0] b, input logic [3:0] rc, input logic [3:0] ec);
    return {s, b, rc, ec};
  endfunction
  task automatic tick();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask
  always @(negedge ACLK) begin
    vectors++;
    if (phy.PREQ && !phy.PHY_ARSTn) begin
      miscompares++;
      $display("FAIL preq_vs_reset: PREQ=%b PHY_ARSTn=%b required PREQ=0 while in reset", phy.PREQ, phy.PHY_ARSTn);
    end
  end
  task automatic test_reset();
    ARST = 1'b1; EN = 1'b0; PWR_REQ = 1'b1;
    phy.STATUS = 4'd0; phy.ECODE = 4'd0; phy.PACCEPT = 1'b0;
    tick(); tick();
    sb.push_back(mk(3'd0, 5'b01000, 4'd0, 4'd0));
    exp = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL reset_idle: got %h expected %h", got, exp); end
    EN = 1'b1;
    tick();
    sb.push_back(mk(3'd0, 5'b01000, 4'd0, 4'd0));
    exp = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL reset_over_en: got %h expected %h", got, exp); end
  endtask
  task automatic test_bringup();
    int low_cyc, link_at;
    low_cyc = 0; link_at = 0;
    sb.push_back(16'd16);
    sb.push_back(16'd20);
    sb.push_back(mk(3'd3, 5'b11010, 4'd0, 4'd0));
    ARST = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 20) phy.STATUS = 4'b0100;
      tick();
      if (!phy.PHY_ARSTn) low_cyc++;
      if (LINK_UP && link_at == 0) link_at = c;
    end
    exp = sb.pop_front(); vectors++;
    if (16'(low_cyc) !== exp) begin miscompares++; $display("FAIL bringup_rst_len: got %0d expected %0d", low_cyc, exp); end
    exp = sb.pop_front(); vectors++;
    if (16'(link_at) !== exp) begin miscompares++; $display("FAIL bringup_link_cycle: got %0d expected %0d", link_at, exp); end
    exp = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL bringup_run: got %h expected %h", got, exp); end
  endtask
  task automatic test_runtime_error();
    sb.push_back(mk(3'd1, 5'b01000, 4'd1, 4'h5));
    sb.push_back(mk(3'd3, 5'b11010, 4'd0, 4'h5));
    phy.ECODE = 4'h5;
    tick();
    phy.ECODE = 4'h0;
    exp = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL runtime_err: got %h expected %h", got, exp); end
    for (int i = 0; i < 100 && !LINK_UP; i++) tick();
    exp = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL runtime_recover: got %h expected %h", got, exp); end
  endtask
  task automatic test_power_cycle();
    sb.push_back(mk(3'd4, 5'b10100, 4'd0, 4'h5));
    sb.push_back(mk(3'd5, 5'b10000, 4'd0, 4'h5));
    sb.push_back(mk(3'd6, 5'b11100, 4'd0, 4'h5));
    sb.push_back(mk(3'd2, 5'b11000, 4'd0, 4'h5));
    sb.push_back(mk(3'd3, 5'b11010, 4'd0, 4'h5));
    PWR_REQ = 1'b0;
    tick();
    exp = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL pwr_dn: got %h expected %h", got, exp); end
    repeat (4) tick();
    phy.PACCEPT = 1'b1;
    tick();
    phy.PACCEPT = 1'b0;
    exp = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL lowpwr: got %h expected %h", got, exp); end
    PWR_REQ = 1'b1; phy.PACCEPT = 1'b1;
    tick();
    exp = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL pwr_up: got %h expected %h", got, exp); end
    tick();
    phy.PACCEPT = 1'b0;
    exp = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL pwr_wait_link: got %h expected %h", got, exp); end
    tick();
    exp = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL pwr_run: got %h expected %h", got, exp); end
  endtask
  task automatic test_simultaneous();
    sb.push_back(mk(3'd1, 5'b01000, 4'd1, 4'h0));
    sb.push_back(mk(3'd2, 5'b11000, 4'd1, 4'h0));
    sb.push_back(mk(3'd0, 5'b01000, 4'd1, 4'h0));
    phy.STATUS = 4'd0; PWR_REQ = 1'b0;
    tick();
    PWR_REQ = 1'b1;
    exp = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL fail_over_pwr: got %h expected %h", got, exp); end
    for (int i = 0; i < 40 && CTRL_STATE != 3'd2; i++) tick();
    repeat (63) tick();
    exp = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL timeout_edge: got %h expected %h", got, exp); end
    EN = 1'b0; phy.ECODE = 4'h3;
    tick();
    phy.ECODE = 4'h0;
    exp = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL en_over_fail: got %h expected %h", got, exp); end
  endtask
  task automatic test_retries();
    logic [2:0] prev;
    ARST = 1'b1;
    tick();
    ARST = 1'b0; EN = 1'b1; phy.STATUS = 4'd0; phy.ECODE = 4'hA;
    for (int r = 0; r <= 3; r++) sb.push_back(16'(r));
    prev = CTRL_STATE;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (CTRL_STATE == 3'd1 && prev != 3'd1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL retry_extra_entry: got RETRY_CNT %0d expected no further PHY_RST entry", RETRY_CNT);
        end else begin
          exp = sb.pop_front();
          if ({12'd0, RETRY_CNT} !== exp) begin miscompares++; $display("FAIL retry_cnt: got %0d expected %0d", RETRY_CNT, exp); end
        end
      end
      prev = CTRL_STATE;
      if (CTRL_STATE == 3'd7) break;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL retry_entries: got %0d missing PHY_RST entries expected 0", sb.size());
      sb.delete();
    end
    sb.push_back(mk(3'd7, 5'b01001, 4'd3, 4'hA));
    sb.push_back(mk(3'd7, 5'b01001, 4'd3, 4'hA));
    sb.push_back(mk(3'd0, 5'b01000, 4'd0, 4'hA));
    exp = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL fault_entry: got %h expected %h", got, exp); end
    repeat (5) tick();
    exp = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL fault_hold: got %h expected %h", got, exp); end
    EN = 1'b0; phy.ECODE = 4'h0;
    tick();
    exp = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL fault_exit: got %h expected %h", got, exp); end
  endtask
  task automatic test_reset_mid_handshake();
    sb.push_back(mk(3'd4, 5'b10100, 4'd0, 4'hA));
    sb.push_back(mk(3'd0, 5'b01000, 4'd0, 4'h0));
    sb.push_back(mk(3'd1, 5'b01000, 4'd0, 4'h0));
    EN = 1'b1; phy.STATUS = 4'b0100; PWR_REQ = 1'b1;
    for (int i = 0; i < 100 && !LINK_UP; i++) tick();
    PWR_REQ = 1'b0;
    tick();
    exp = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL mid_pwr_dn: got %h expected %h", got, exp); end
    ARST = 1'b1;
    tick();
    exp = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL mid_reset: got %h expected %h", got, exp); end
    ARST = 1'b0; phy.PACCEPT = 1'b1;
    tick();
    phy.PACCEPT = 1'b0;
    exp = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL mid_paccept_ignored: got %h expected %h", got, exp); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_bringup();
    test_runtime_error();
    test_power_cycle();
    test_simultaneous();
    test_retries();
    test_reset_mid_handshake();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/qeciphy_link_ctrl.md
QECIPHY_LINK_CTRL -- requirements
Module: qeciphy_link_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: number of cycles PHY_ARSTn is held low per reset attempt (range 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65536: link-up and handshake timeout in ACLK cycles (range 16..2^24).
REQ-003 SHALL have parameter MAX_RETRY, default 3: reset attempts allowed after the first failure before FAULT (range 0..15).
REQ-004 SHALL have one clock, ACLK, and a synchronous active-high reset, ARST; all logic is clocked on the rising edge of ACLK.
REQ-005 ports: ACLK  in  1  clock.
REQ-006 ports: ARST  in  1  synchronous active-high reset.
REQ-007 ports: EN  in  1  enable link bring-up; 0 forces IDLE.
REQ-008 ports: PWR_REQ  in  1  host power request; 1 = run, 0 = low power.
REQ-009 ports: STATUS  in  4  PHY status; 4'b0100 = link ready.
REQ-010 ports: ECODE  in  4  PHY error code; 0 = no error.
REQ-011 ports: PACCEPT  in  1  PHY power-handshake accept.
REQ-012 ports: PHY_ARSTn  out  1  active-low reset to the PHY.
REQ-013 ports: PSTATE  out  1  requested PHY power state.
REQ-014 ports: PREQ  out  1  PHY power-handshake request.
REQ-015 ports: LINK_UP  out  1  link usable by the AXI datapath.
REQ-016 ports: FAULT  out  1  retries exhausted.
REQ-017 ports: RETRY_CNT  out  4  failed attempts since the last LINK_UP.
REQ-018 ports: LAST_ECODE  out  4  ECODE captured at the most recent failure.
REQ-019 ports: CTRL_STATE  out  3  current FSM state encoding.

Function
REQ-020 FSM states and encodings SHALL be IDLE=0, PHY_RST=1, WAIT_LINK=2, RUN=3, PWR_DN=4, LOWPWR=5, PWR_UP=6, FAULT=7.
REQ-021 All outputs SHALL be registered; an output change SHALL appear one cycle after the input edge that causes it.
REQ-022 IDLE: PHY_ARSTn=0, PREQ=0, PSTATE=1; EN=1 -> PHY_RST, and the RST_CYCLES counter is loaded.
REQ-023 PHY_RST: PHY_ARSTn=0 for exactly RST_CYCLES cycles -> WAIT_LINK, with PHY_ARSTn=1 and the timeout timer cleared.
REQ-024 WAIT_LINK: STATUS==4'b0100 and ECODE==0 -> RUN, with LINK_UP=1 and RETRY_CNT cleared; the timer reaching TIMEOUT_CYCLES-1 is a failure.
REQ-025 RUN: STATUS!=4'b0100 or ECODE!=0 is a failure; PWR_REQ=0 -> PWR_DN, with PSTATE=0, PREQ=1, LINK_UP=0 and the timer cleared. A failure takes priority over PWR_REQ in the same cycle.
REQ-026 PWR_DN: PACCEPT=1 -> LOWPWR with PREQ=0; a timeout is a failure.
REQ-027 LOWPWR: PSTATE=0, PREQ=0; PWR_REQ=1 -> PWR_UP, with PSTATE=1, PREQ=1 and the timer cleared.
REQ-028 PWR_UP: PACCEPT=1 -> WAIT_LINK with PREQ=0 and the timer cleared; a timeout is a failure.
REQ-029 On a failure, LAST_ECODE SHALL capture ECODE, LINK_UP=0 and PREQ=0.
REQ-030 On a failure with RETRY_CNT==MAX_RETRY, the FSM SHALL go to FAULT; otherwise RETRY_CNT SHALL increment by 1 and the FSM SHALL go to PHY_RST.
REQ-031 FAULT: FAULT=1, PHY_ARSTn=0; the FSM SHALL exit only via EN=0 -> IDLE, which clears FAULT and RETRY_CNT; LAST_ECODE is held.
REQ-032 EN=0 in any state SHALL go to IDLE next cycle, with PHY_ARSTn=0, PREQ=0 and LINK_UP=0; this has priority over all other transitions.
REQ-033 RETRY_CNT SHALL saturate at MAX_RETRY and never wrap.
REQ-034 The timer SHALL be 24 bits wide, SHALL stop at TIMEOUT_CYCLES-1, and SHALL not wrap.
REQ-035 PREQ SHALL never be 1 while PHY_ARSTn=0.

Reset
REQ-036 While ARST=1 the outputs SHALL be: CTRL_STATE=IDLE, PHY_ARSTn=0, PSTATE=1, PREQ=0, LINK_UP=0, FAULT=0, RETRY_CNT=0, LAST_ECODE=0, with all counters at 0.
REQ-037 Assertion of ARST in any state, including mid-handshake, SHALL take effect at the next ACLK edge.

Verification
REQ-038 Bring-up: EN=1, with STATUS=4'b0100 and ECODE=0 from cycle 20 -> PHY_ARSTn low for 16 cycles, then LINK_UP=1 at the first qualifying cycle plus 1.
REQ-039 Retries to fault (TIMEOUT_CYCLES=64, MAX_RETRY=3): EN=1 with STATUS held at 0 -> three PHY_RST re-entries with RETRY_CNT going 1, 2, 3, then FAULT=1; EN=0 -> IDLE with FAULT=0 and RETRY_CNT=0.
REQ-040 Runtime error: in RUN, drive ECODE=4'h5 for 1 cycle -> LINK_UP=0, LAST_ECODE=5, RETRY_CNT=1, state PHY_RST; after the link recovers, RETRY_CNT=0.
REQ-041 Power cycle: in RUN, PWR_REQ=0 -> PSTATE=0 and PREQ=1; PACCEPT=1 after 5 cycles -> PREQ=0 and LOWPWR. Then PWR_REQ=1 and PACCEPT=1 -> WAIT_LINK, followed by RUN.
REQ-042 Simultaneous events: STATUS drop and PWR_REQ=0 in the same RUN cycle -> failure path taken; EN=0 together with a failure -> IDLE with RETRY_CNT unchanged.
REQ-043 Reset mid-handshake: ARST=1 in PWR_DN -> next cycle all outputs at the REQ-036 values; PACCEPT arriving afterwards is ignored.
